// File: rtl/fifo_rd_sched_if.sv
// Handshake and data bundle between the read-side job sequencer and its environment.
interface fifo_rd_sched_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] cfg_len;
   logic             busy;
   logic             done;
   logic             fifo_rinc;
   logic             fifo_rempty;
   logic [WIDTH-1:0] fifo_rdata;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;

   // Sequencer side
   modport slave (
      input  start, cfg_len, fifo_rempty, fifo_rdata, out_ready,
      output busy, done, fifo_rinc, out_valid, out_data, out_last
   );

   // Environment side (job requester, FIFO and downstream sink)
   modport master (
      output start, cfg_len, fifo_rempty, fifo_rdata, out_ready,
      input  busy, done, fifo_rinc, out_valid, out_data, out_last
   );
endinterface

// File: rtl/fifo_rd_sched.sv
// Read-side job sequencer: pops cfg_len words from the SRAM FIFO, absorbs its read
// latency in a credit-checked buffer and streams the words out with a last marker.
module fifo_rd_sched #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned RD_LAT = 2,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned LEN_W  = 8
) (
   input  logic           rclk,
   input  logic           rst_n,
   fifo_rd_sched_if.slave bus
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);
   localparam int unsigned IFL_W = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] job_len_q, job_len_d;
   logic [LEN_W-1:0] issued_q, issued_d;
   logic [LEN_W-1:0] sent_q, sent_d;
   logic [RD_LAT-1:0] vld_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0] occ_q;
   logic [IFL_W-1:0] inflight;
   logic             rinc, push, pop, out_valid, out_last, credit_ok;

   // Number of pops whose data has not yet reached the buffer
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + IFL_W'(vld_q[i]);
   end

   assign out_valid = (occ_q != '0);
   assign pop       = out_valid && bus.out_ready;
   assign push      = vld_q[RD_LAT-1];
   assign credit_ok = (32'(occ_q) + 32'(inflight)) < DEPTH;
   assign out_last  = out_valid && (sent_q == job_len_q - LEN_W'(1));

   assign bus.fifo_rinc = rinc;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.out_valid = out_valid;
   assign bus.out_last  = out_last;
   assign bus.out_data  = mem_q[rd_ptr_q];

   // State and job counter registers
   always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         job_len_q <= '0;
         issued_q  <= '0;
         sent_q    <= '0;
      end else begin
         state_q   <= state_d;
         job_len_q <= job_len_d;
         issued_q  <= issued_d;
         sent_q    <= sent_d;
      end
   end

   // Next-state, pop issue and counter updates
   always_comb begin
      state_d   = state_q;
      job_len_d = job_len_q;
      issued_d  = issued_q;
      sent_d    = sent_q;
      rinc      = 1'b0;
      if (pop) sent_d = sent_q + LEN_W'(1);
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               job_len_d = bus.cfg_len;
               issued_d  = '0;
               sent_d    = '0;
               state_d   = (bus.cfg_len != '0) ? S_ISSUE : S_DONE;
            end
         end
         S_ISSUE: begin
            rinc = !bus.fifo_rempty && (issued_q < job_len_q) && credit_ok;
            if (rinc) begin
               issued_d = issued_q + LEN_W'(1);
               if (issued_d == job_len_q) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && out_last) state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // In-flight pipe and circular output buffer
   always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         vld_q[0] <= rinc;
         for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
         if (push) begin
            mem_q[wr_ptr_q] <= bus.fifo_rdata;
            wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop)      occ_q <= occ_q + OCC_W'(1);
         else if (!push && pop) occ_q <= occ_q - OCC_W'(1);
      end
   end
endmodule

// File: tb/tb_fifo_rd_sched.sv
// Bench for fifo_rd_sched: FIFO environment with fixed read latency and a
// queue-based model of which words each job must deliver.
module tb_fifo_rd_sched;
   localparam int unsigned WIDTH  = 32;
   localparam int unsigned RD_LAT = 2;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned LEN_W  = 8;

   logic rclk  = 1'b0;
   logic rst_n = 1'b0;

   fifo_rd_sched_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

   fifo_rd_sched #(.WIDTH(WIDTH), .RD_LAT(RD_LAT), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .rclk (rclk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 rclk = ~rclk;

   int total = 0;
   int bad   = 0;

   // FIFO environment: contents, pointers and the read-latency pipe
   logic [WIDTH-1:0] fifo_mem [1024];
   int               fifo_wr = 0;
   int               fifo_rd = 0;
   logic             starve  = 1'b0;
   logic [WIDTH-1:0] rpipe [RD_LAT];

   assign bus.fifo_rempty = (fifo_wr == fifo_rd) || starve;
   assign bus.fifo_rdata  = rpipe[RD_LAT-1];

   always @(posedge rclk) begin
      for (int i = RD_LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
      if (bus.fifo_rinc) begin
         rpipe[0] <= fifo_mem[fifo_rd];
         fifo_rd  <= fifo_rd + 1;
      end else begin
         rpipe[0] <= 32'hDEAD_BEEF;
      end
   end

   task automatic load_fifo(input int n, input bit seq, input int base);
      for (int i = 0; i < n; i++) begin
         fifo_mem[fifo_wr] = seq ? WIDTH'(base + i) : WIDTH'($urandom);
         fifo_wr = fifo_wr + 1;
      end
   endtask

   // Runs one job and checks every cycle against the queue of expected words
   task automatic run_job(input int len, input int ready_pct, input int hold,
                          input int starve_at, input int starve_len, input int abort_after,
                          input bit poke_start, input string tag, output int pop_span);
      logic [WIDTH-1:0] exp_q[$];
      int cyc = 0, got = 0, pops = 0, starve_left = 0, first_pop = -1, last_pop = -1;
      bit hs_last, hs_now, finished = 0, starved = 0, poked = 0, timed_out = 0, aborted = 0;
      for (int i = 0; i < len; i++) exp_q.push_back(fifo_mem[fifo_rd + i]);
      @(negedge rclk);
      bus.start   = 1'b1;
      bus.cfg_len = LEN_W'(len);
      @(negedge rclk);
      bus.start   = 1'b0;
      bus.cfg_len = LEN_W'($urandom);
      hs_last = (len == 0);
      while (!finished) begin
         if (cyc >= 400) begin
            total++; bad++; timed_out = 1;
            $display("FAIL %s timeout: got=%0d words, required=%0d", tag, got, len);
            break;
         end
         if (abort_after > 0 && got == abort_after) begin
            rst_n = 1'b0;
            #1;
            total++;
            if ({bus.busy, bus.done, bus.fifo_rinc, bus.out_valid, bus.out_last} !== 5'b0 ||
                bus.out_data !== '0) begin
               bad++;
               $display("FAIL %s reset_outputs: flags=%b data=%h, required flags=00000 data=0", tag,
                        {bus.busy, bus.done, bus.fifo_rinc, bus.out_valid, bus.out_last}, bus.out_data);
            end
            @(negedge rclk);
            rst_n   = 1'b1;
            aborted = 1;
            break;
         end
         if (hold > 0 && cyc < hold) bus.out_ready = 1'b0;
         else bus.out_ready = ($urandom_range(0, 99) < ready_pct);
         if (starve_left > 0) begin
            starve_left--;
            if (starve_left == 0) starve = 1'b0;
         end else if (starve_at > 0 && pops == starve_at && !starved) begin
            starve = 1'b1; starve_left = starve_len; starved = 1;
         end
         if (poke_start && !poked && len > 0 && pops == len && !hs_last) begin
            bus.start = 1'b1; bus.cfg_len = LEN_W'(9); poked = 1;
         end else begin
            bus.start = 1'b0;
         end
         #1;
         total++;
         if (bus.done !== hs_last) begin
            bad++;
            $display("FAIL %s done cyc=%0d: got=%b required=%b", tag, cyc, bus.done, hs_last);
         end
         total++;
         if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy cyc=%0d: got=%b required=1", tag, cyc, bus.busy);
         end
         total++;
         if (bus.fifo_rinc === 1'b1 && (bus.fifo_rempty === 1'b1 || pops >= len)) begin
            bad++;
            $display("FAIL %s rinc cyc=%0d: got=1 required=0 (rempty=%b pops=%0d len=%0d)",
                     tag, cyc, bus.fifo_rempty, pops, len);
         end
         if (hold > 0 && cyc == hold) begin
            total++;
            if (pops !== ((len < DEPTH) ? len : DEPTH) || bus.fifo_rinc !== 1'b0 || bus.out_valid !== 1'b1) begin
               bad++;
               $display("FAIL %s hold_pops: pops=%0d rinc=%b valid=%b required pops=%0d rinc=0 valid=1",
                        tag, pops, bus.fifo_rinc, bus.out_valid, DEPTH);
            end
         end
         if (hs_last) finished = 1;
         hs_now = 0;
         if (bus.out_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL %s extra_word cyc=%0d: got valid data=%h required no word", tag, cyc, bus.out_data);
            end else if (bus.out_data !== exp_q[0] || bus.out_last !== (exp_q.size() == 1)) begin
               bad++;
               $display("FAIL %s word%0d: got data=%h last=%b required data=%h last=%b",
                        tag, got, bus.out_data, bus.out_last, exp_q[0], exp_q.size() == 1);
            end
            if (bus.out_ready && exp_q.size() != 0) begin
               void'(exp_q.pop_front());
               got++;
               hs_now = (exp_q.size() == 0);
            end
         end
         if (bus.fifo_rinc === 1'b1) begin
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            pops++;
         end
         hs_last = hs_now;
         @(negedge rclk);
         cyc++;
      end
      bus.start = 1'b0;
      starve    = 1'b0;
      pop_span  = last_pop - first_pop;
      if (!timed_out && !aborted) begin
         #1;
         total++;
         if (bus.busy !== 1'b0 || bus.done !== 1'b0 || pops != len) begin
            bad++;
            $display("FAIL %s end: busy=%b done=%b pops=%0d required busy=0 done=0 pops=%0d",
                     tag, bus.busy, bus.done, pops, len);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.cfg_len = '0; bus.out_ready = 1'b0;
      #12;
      total++;
      if ({bus.busy, bus.done, bus.fifo_rinc, bus.out_valid, bus.out_last} !== 5'b0 || bus.out_data !== '0) begin
         bad++;
         $display("FAIL reset: flags=%b data=%h required flags=00000 data=0",
                  {bus.busy, bus.done, bus.fifo_rinc, bus.out_valid, bus.out_last}, bus.out_data);
      end
      @(negedge rclk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int span;
      load_fifo(8, 1, 0);
      run_job(5, 100, 0, 0, 0, 0, 0, "basic", span);
      total++;
      if (span !== 4) begin
         bad++;
         $display("FAIL basic pop_span: got=%0d required=4", span);
      end
      total++;
      if (fifo_wr - fifo_rd !== 3 || fifo_mem[fifo_rd] !== 32'd5) begin
         bad++;
         $display("FAIL basic leftover: got=%0d head=%0d required=3 head=5", fifo_wr - fifo_rd, fifo_mem[fifo_rd]);
      end
      fifo_rd = fifo_wr;
   endtask

   task automatic test_backpressure();
      int span;
      load_fifo(16, 1, 100);
      run_job(10, 100, 12, 0, 0, 0, 0, "backpressure", span);
   endtask

   task automatic test_starve();
      int span;
      load_fifo(12, 0, 0);
      run_job(8, 80, 0, 2, 10, 0, 0, "starve", span);
   endtask

   task automatic test_zero_len();
      int span;
      run_job(0, 100, 0, 0, 0, 0, 0, "zero_len", span);
   endtask

   task automatic test_reset_mid();
      int span;
      load_fifo(12, 1, 200);
      run_job(8, 100, 0, 0, 0, 3, 0, "reset_mid", span);
      run_job(2, 100, 0, 0, 0, 0, 0, "after_reset", span);
   endtask

   task automatic test_start_in_drain();
      int span;
      load_fifo(20, 0, 0);
      run_job(10, 40, 0, 0, 0, 0, 1, "start_in_drain", span);
      repeat (3) begin
         @(negedge rclk);
         total++;
         if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL start_in_drain idle: busy=%b required=0", bus.busy);
         end
      end
   endtask

   task automatic test_random();
      int span, len;
      for (int j = 0; j < 6; j++) begin
         len = $urandom_range(1, 20);
         load_fifo(len + $urandom_range(0, 3), 0, 0);
         run_job(len, $urandom_range(30, 100), 0, (j % 2) ? $urandom_range(1, 3) : 0,
                 $urandom_range(1, 6), 0, 0, "random", span);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_starve();
      test_zero_len();
      test_reset_mid();
      test_start_in_drain();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end
endmodule
